// File: rtl/button_arbiter_pkg.sv
// Shared types and symbol codes for the pushbutton front end and the entry logic.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package button_arbiter_pkg;

  // Arbitration FSM: waiting for a gesture, or absorbing the rest of one
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HELD = 1'b1
  } arb_state_t;

  typedef logic [1:0] sym_t;

  // Symbol codes shared with the password/try entry logic
  localparam sym_t SYM_NONE = 2'b00;
  localparam sym_t SYM_B0   = 2'b01;
  localparam sym_t SYM_B1   = 2'b10;
  localparam sym_t SYM_B2   = 2'b11;

  localparam int NUM_BUTTONS = 3;

  // Highest-index button wins when several press events coincide
  function automatic sym_t pick_symbol(input logic [NUM_BUTTONS-1:0] evt);
    sym_t sym;
    sym = SYM_NONE;
    if (evt[2]) begin
      sym = SYM_B2;
    end else if (evt[1]) begin
      sym = SYM_B1;
    end else if (evt[0]) begin
      sym = SYM_B0;
    end
    return sym;
  endfunction

endpackage

// File: rtl/button_arbiter_debounce_filter.sv
// Two-flop synchroniser plus stable-level debounce for one active-low button.
// Latency: level change accepted DEBOUNCE_CYCLES+2 edges after the raw pin settles.
// Backpressure: none; free-running filter.
module debounce_filter #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic clk,
  input  logic async_reset,
  input  logic button_raw,
  output logic pressed
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 s1;
  logic                 s2;
  logic                 sync_lvl;
  logic [CNT_WIDTH-1:0] cnt;

  // Synchroniser; resets to the released (high) pin level
  always_ff @(posedge clk) begin
    if (!async_reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= button_raw;
      s2 <= s1;
    end
  end

  assign sync_lvl = ~s2;

  // Count consecutive cycles of disagreement; any bounce back restarts the count
  always_ff @(posedge clk) begin
    if (!async_reset) begin
      cnt     <= '0;
      pressed <= 1'b0;
    end else if (sync_lvl != pressed) begin
      if (cnt == CNT_LAST) begin
        pressed <= sync_lvl;
        cnt     <= '0;
      end else begin
        cnt <= cnt + CNT_WIDTH'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/button_arbiter.sv
// Debounces 3 pushbuttons, arbitrates each press gesture to one symbol, queues symbols.
// Latency: symbol_valid rises DEBOUNCE_CYCLES+3 edges after a stable raw press.
// Backpressure: valid/ready pop; when full without a pop a new symbol is dropped and overflow sticks.
module button_arbiter
  import button_arbiter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_WIDTH       = 20,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic       clk,
  input  logic       async_reset,
  input  logic [2:0] buttons_raw,
  input  logic       flush,
  input  logic       clear_overflow,
  input  logic       symbol_ready,
  output logic       symbol_valid,
  output logic [1:0] symbol_data,
  output logic [2:0] pressed,
  output logic       overflow
);

  localparam int               PTR_W    = $clog2(FIFO_DEPTH);
  localparam int               OCC_W    = PTR_W + 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

  logic [2:0]       pressed_d;
  logic [2:0]       press_evt;
  arb_state_t       state;
  arb_state_t       state_nxt;
  logic             push_req;
  sym_t             push_sym;
  sym_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic             fifo_full;
  logic             pop;
  logic             push_ok;
  logic             ovf_set;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    debounce_filter #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_WIDTH      (CNT_WIDTH)
    ) u_debounce (
      .clk        (clk),
      .async_reset(async_reset),
      .button_raw (buttons_raw[i]),
      .pressed    (pressed[i])
    );
  end

  // Delayed debounced level for rising-edge (press) detection
  always_ff @(posedge clk) begin
    if (!async_reset) begin
      pressed_d <= '0;
    end else begin
      pressed_d <= pressed;
    end
  end

  assign press_evt = pressed & ~pressed_d;

  // Arbitration state register; flush deliberately leaves it alone
  always_ff @(posedge clk) begin
    if (!async_reset) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // One symbol per gesture: first press event pushes, then wait for all buttons released
  always_comb begin
    state_nxt = state;
    push_req  = 1'b0;
    push_sym  = pick_symbol(press_evt);
    case (state)
      ARB_IDLE: begin
        if (|press_evt) begin
          push_req  = 1'b1;
          state_nxt = ARB_HELD;
        end
      end
      ARB_HELD: begin
        if (pressed == 3'b000) begin
          state_nxt = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  assign fifo_full    = (occ == OCC_FULL);
  assign symbol_valid = (occ != '0);
  assign pop          = symbol_valid & symbol_ready & ~flush;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign push_ok      = push_req & ~flush & (~fifo_full | pop);
  assign ovf_set      = push_req & ~flush & fifo_full & ~pop;
  assign symbol_data  = symbol_valid ? mem[rd_ptr] : SYM_NONE;

  // Symbol storage; contents are only meaningful below the occupancy count
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_sym;
    end
  end

  // Pointers and occupancy; flush empties the queue and beats any push or pop
  always_ff @(posedge clk) begin
    if (!async_reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Sticky overflow; a new drop in the same cycle as a clear keeps it set
  always_ff @(posedge clk) begin
    if (!async_reset) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (clear_overflow) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_button_arbiter.sv
// Randomized and directed bench for button_arbiter with a behavioural reference model.
// Latency: checks outputs every cycle on the falling edge against the model.
// Backpressure: drives symbol_ready randomly or per scenario.
module tb_button_arbiter;

  localparam int DC    = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       async_reset;
  logic [2:0] buttons_raw;
  logic       flush;
  logic       clear_overflow;
  logic       symbol_ready;
  logic       symbol_valid;
  logic [1:0] symbol_data;
  logic [2:0] pressed;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [2:0] raw_1 = 3'b111;   // raw level one edge ago
  logic [2:0] raw_2 = 3'b111;   // raw level two edges ago
  logic [2:0] lvl_m = 3'b000;   // debounced level
  logic [2:0] lvl_prev_m = 3'b000;
  int         streak [3] = '{0, 0, 0};
  bit         in_gesture = 1'b0;
  bit         ovf_m = 1'b0;
  logic [1:0] mq [$];           // expected FIFO contents, head first
  logic [1:0] acc [$];          // symbols actually accepted from the DUT
  bit         mon_en = 1'b0;

  logic [2:0] evt_m;
  logic [2:0] sync_m;
  logic [1:0] sym_m;
  bit         want_push;
  bit         do_pop;
  bit         drop;

  always #5 clk = ~clk;

  button_arbiter #(
    .DEBOUNCE_CYCLES(DC),
    .CNT_WIDTH      (8),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk           (clk),
    .async_reset   (async_reset),
    .buttons_raw   (buttons_raw),
    .flush         (flush),
    .clear_overflow(clear_overflow),
    .symbol_ready  (symbol_ready),
    .symbol_valid  (symbol_valid),
    .symbol_data   (symbol_data),
    .pressed       (pressed),
    .overflow      (overflow)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare accepted symbols with an expected list packed two bits per entry, entry 0 lowest
  task automatic check_acc(input string name, input int n, input logic [15:0] exp_packed);
    logic [15:0] e;
    e = exp_packed;
    check({name, "_count"}, acc.size(), n);
    for (int k = 0; k < n && k < acc.size(); k++) begin
      check({name, "_sym"}, int'(acc[k]), int'(e[2*k +: 2]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic tap(input int b);
    buttons_raw[b] = 1'b0;
    idle(8);
    buttons_raw[b] = 1'b1;
    idle(8);
  endtask

  // Behavioural model: a level is accepted after DC consecutive synchronised disagreements,
  // the first press of a gesture yields the highest-index symbol, queue of DEPTH entries.
  always @(posedge clk) begin
    if (!async_reset) begin
      raw_1      = 3'b111;
      raw_2      = 3'b111;
      lvl_m      = 3'b000;
      lvl_prev_m = 3'b000;
      for (int i = 0; i < 3; i++) streak[i] = 0;
      in_gesture = 1'b0;
      ovf_m      = 1'b0;
      mq.delete();
    end else begin
      evt_m     = lvl_m & ~lvl_prev_m;
      want_push = 1'b0;
      sym_m     = 2'd0;
      if (!in_gesture && evt_m != 3'b000) begin
        want_push  = 1'b1;
        sym_m      = evt_m[2] ? 2'd3 : (evt_m[1] ? 2'd2 : 2'd1);
        in_gesture = 1'b1;
      end else if (in_gesture && lvl_m == 3'b000) begin
        in_gesture = 1'b0;
      end
      drop = 1'b0;
      if (flush) begin
        mq.delete();
      end else begin
        do_pop = (mq.size() > 0) && symbol_ready;
        if (want_push && mq.size() == DEPTH && !do_pop) drop = 1'b1;
        if (do_pop) void'(mq.pop_front());
        if (want_push && !drop) mq.push_back(sym_m);
      end
      if (clear_overflow) ovf_m = 1'b0;
      if (drop) ovf_m = 1'b1;
      lvl_prev_m = lvl_m;
      sync_m     = ~raw_2;
      for (int i = 0; i < 3; i++) begin
        if (sync_m[i] != lvl_m[i]) begin
          streak[i]++;
          if (streak[i] == DC) begin
            lvl_m[i]  = sync_m[i];
            streak[i] = 0;
          end
        end else begin
          streak[i] = 0;
        end
      end
      raw_2 = raw_1;
      raw_1 = buttons_raw;
    end
  end

  // Monitor: compare DUT outputs with the model and log every accepted symbol
  always @(negedge clk) begin
    if (mon_en) begin
      check("mon_valid", symbol_valid, mq.size() != 0);
      check("mon_data", symbol_data, (mq.size() != 0) ? int'(mq[0]) : 0);
      check("mon_pressed", pressed, lvl_m);
      check("mon_overflow", overflow, ovf_m);
      if (symbol_valid && symbol_ready) acc.push_back(symbol_data);
    end
  end

  int hold [3];

  initial begin
    async_reset    = 1'b0;
    buttons_raw    = 3'b111;
    flush          = 1'b0;
    clear_overflow = 1'b0;
    symbol_ready   = 1'b1;
    idle(3);
    check("reset_valid", symbol_valid, 0);
    check("reset_data", symbol_data, 0);
    check("reset_pressed", pressed, 0);
    check("reset_overflow", overflow, 0);
    async_reset = 1'b1;
    mon_en      = 1'b1;
    idle(2);

    // 1. Clean press: pressed from edge 6, valid exactly at edge 7
    acc.delete();
    buttons_raw[0] = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      tick();
      check("t1_valid", symbol_valid, n == 7);
      check("t1_pressed0", pressed[0], n >= 6);
    end
    idle(10);
    buttons_raw[0] = 1'b1;
    idle(15);
    check_acc("t1_acc", 1, 16'h0001);

    // 2. Bounce: toggling every 2 cycles never settles
    acc.delete();
    for (int c = 0; c < 12; c++) begin
      buttons_raw[1] = ((c / 2) % 2) != 0;
      tick();
    end
    check("t2_no_sym_bouncing", acc.size(), 0);
    buttons_raw[1] = 1'b0;
    idle(12);
    buttons_raw[1] = 1'b1;
    idle(12);
    check_acc("t2_acc", 1, 16'h0002);

    // 3. Chord: btn0+btn2 together -> one btn2 symbol; re-press of btn0 inside gesture ignored
    acc.delete();
    buttons_raw = 3'b010;
    idle(10);
    check_acc("t3_chord", 1, 16'h0003);
    buttons_raw[0] = 1'b1;
    idle(10);
    buttons_raw[0] = 1'b0;
    idle(10);
    buttons_raw = 3'b111;
    idle(12);
    check_acc("t3_after", 1, 16'h0003);

    // 4. Overflow: five presses into a 4-entry queue
    acc.delete();
    symbol_ready = 1'b0;
    tap(0); tap(1); tap(2); tap(0); tap(1);
    check("t4_overflow_set", overflow, 1);
    check("t4_valid_full", symbol_valid, 1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check("t4_overflow_clr", overflow, 0);
    symbol_ready = 1'b1;
    idle(8);
    check_acc("t4_drain", 4, 16'b01_11_10_01);

    // 5. Full queue, push and pop on the same edge
    acc.delete();
    symbol_ready = 1'b0;
    tap(0); tap(1); tap(0); tap(1);
    buttons_raw[2] = 1'b0;
    idle(6);
    symbol_ready = 1'b1;
    tick();
    symbol_ready = 1'b0;
    check("t5_overflow", overflow, 0);
    check("t5_one_popped", acc.size(), 1);
    buttons_raw = 3'b111;
    idle(8);
    check("t5_still_valid", symbol_valid, 1);
    symbol_ready = 1'b1;
    idle(8);
    check_acc("t5_drain", 5, 16'b11_10_01_10_01);

    // 6a. Flush with 3 queued while a push lands
    acc.delete();
    symbol_ready = 1'b0;
    tap(0); tap(1); tap(2);
    buttons_raw[0] = 1'b0;
    idle(6);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t6_flush_valid", symbol_valid, 0);
    buttons_raw = 3'b111;
    symbol_ready = 1'b1;
    idle(15);
    check("t6_flush_nothing", acc.size(), 0);

    // 6b. Reset mid-debounce discards the press
    acc.delete();
    buttons_raw[1] = 1'b0;
    idle(4);
    async_reset = 1'b0;
    tick();
    async_reset = 1'b1;
    buttons_raw = 3'b111;
    check("t6_rst_valid", symbol_valid, 0);
    check("t6_rst_pressed", pressed, 0);
    check("t6_rst_overflow", overflow, 0);
    idle(15);
    check("t6_rst_nothing", acc.size(), 0);
    check("t6_rst_pressed_late", pressed, 0);

    // Random phase against the model
    for (int i = 0; i < 3; i++) hold[i] = $urandom_range(1, 12);
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 3; i++) begin
        hold[i]--;
        if (hold[i] <= 0) begin
          buttons_raw[i] = ~buttons_raw[i];
          hold[i] = $urandom_range(1, 12);
        end
      end
      symbol_ready   = ($urandom_range(0, 3) != 0);
      flush          = ($urandom_range(0, 63) == 0);
      clear_overflow = ($urandom_range(0, 31) == 0);
      async_reset    = ($urandom_range(0, 499) != 0);
      tick();
    end
    flush          = 1'b0;
    clear_overflow = 1'b0;
    async_reset    = 1'b1;
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
